// File: rtl/fle_carry_accumulator.sv
// Registered accumulator wrapped around a WIDTH-long ripple of CARRY cells.
// Each enabled edge clears, loads, or adds/subtracts D; overflow is sticky.
module fle_carry_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic             SUB,
  input  logic             CIN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             COUT,
  output logic             OVF,
  output logic             VALID
);

  logic [WIDTH-1:0] q_q,     q_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             ripple;

  // Propagate/generate feed the carry cells; c[i] is the carry into bit i.
  always_comb begin
    // NOTE: every variable gets a value before any branch or loop, so no latch can be inferred.
    b_op   = SUB ? ~D : D;
    prop   = q_q ^ b_op;
    gen    = q_q & b_op;
    sum    = '0;
    carry  = '0;
    ripple = SUB | CIN;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = ripple;
      sum[i]   = prop[i] ^ ripple;
      ripple   = prop[i] ? ripple : gen[i];
    end
    carry[WIDTH] = ripple;
  end

  // Priority CLR > LOAD > arithmetic, all gated by E; VALID mirrors E one edge later.
  always_comb begin
    q_d     = q_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = E;
    if (E) begin
      if (CLR) begin
        q_d    = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
      end else if (LOAD) begin
        q_d    = D;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
      end else begin
        q_d    = sum;
        cout_d = carry[WIDTH];
        ovf_d  = ovf_q | (carry[WIDTH] ^ carry[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      q_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      q_q     <= q_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign Q     = q_q;
  assign COUT  = cout_q;
  assign OVF   = ovf_q;
  assign VALID = valid_q;

endmodule
